rtc_bus_sequencer: RTL and testbench

- Owns the multiplexed address/data bus of the external RTC chip (A_D, RD, WR, CS and an 8-bit shared port).
- Shares the bus between two requesters: a write requester (keyboard-driven time/date programming) and a read requester (periodic refresh of the VGA time registers).
- Sequences each access as an address phase, a gap, then a data phase.
- The tristate buffer is instantiated one level up; this block only drives io_out and io_oe and samples io_in.

---
 rtl/rtc_bus_pkg.sv | 33 +++
 rtl/rtc_phase_timer.sv | 33 +++
 rtl/rtc_bus_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC bus sequencer: FSM states, grant direction, strobe bundle.
// With RTC_WRITE_VERIFY_EN defined, the state set includes the write-readback states.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StGap,
    StData,
    StDone
`ifdef RTC_WRITE_VERIFY_EN
    ,
    StVerifyAddr,
    StVerifyGap,
    StVerifyData
`endif
  } state_e;

  typedef enum logic {
    GntRead  = 1'b0,
    GntWrite = 1'b1
  } grant_e;

  typedef struct packed {
    logic a_d;
    logic rd;
    logic wr;
    logic cs;
  } strobes_t;

  localparam strobes_t StrobesIdle = '{a_d: 1'b1, rd: 1'b1, wr: 1'b1, cs: 1'b1};

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; done pulses in the phase's last cycle.
module rtc_phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] length,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= length - CNT_W'(1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign done = active_q && (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Arbitrates write/read requesters onto the multiplexed RTC bus (address, gap, data phases).
// Optional RTC_WRITE_VERIFY_EN: each write is followed by a readback and reports wr_err.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_GAP   = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_ack,
  output logic       A_D,
  output logic       RD,
  output logic       WR,
  output logic       CS,
  output logic [7:0] io_out,
  output logic       io_oe,
  input  logic [7:0] io_in,
  output logic       busy
`ifdef RTC_WRITE_VERIFY_EN
  ,
  output logic       wr_err
`endif
);

  localparam logic [CNT_W-1:0] PulseLen = CNT_W'(T_PULSE);
  localparam logic [CNT_W-1:0] GapLen   = CNT_W'(T_GAP);

  state_e     state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  grant_e     grant_sel;
  grant_e     dir_q;
  logic [7:0] addr_q, data_q, rd_data_q;
  logic       latch;
  logic       tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_len;
  strobes_t   strb;

  rtc_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .length(tmr_len),
    .done  (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_sel    = dir_q;
    latch        = 1'b0;
    tmr_load     = 1'b0;
    tmr_len      = PulseLen;
    case (state_q)
      StIdle: begin
        if (wr_req || rd_req) begin
          // Round-robin on a tie: the side that did not win last time goes next.
          grant_sel    = (wr_req && (!rd_req || last_grant_q == GntRead)) ? GntWrite : GntRead;
          last_grant_d = grant_sel;
          latch        = 1'b1;
          tmr_load     = 1'b1;
          state_d      = StAddr;
        end
      end
      StAddr: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_len  = GapLen;
          state_d  = StGap;
        end
      end
      StGap: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          state_d  = StData;
        end
      end
      StData: begin
        if (tmr_done) begin
`ifdef RTC_WRITE_VERIFY_EN
          if (dir_q == GntWrite) begin
            tmr_load = 1'b1;
            state_d  = StVerifyAddr;
          end else begin
            state_d = StDone;
          end
`else
          state_d = StDone;
`endif
        end
      end
`ifdef RTC_WRITE_VERIFY_EN
      StVerifyAddr: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_len  = GapLen;
          state_d  = StVerifyGap;
        end
      end
      StVerifyGap: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          state_d  = StVerifyData;
        end
      end
      StVerifyData: begin
        if (tmr_done) begin
          state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    strb   = StrobesIdle;
    io_oe  = 1'b0;
    io_out = 8'h00;
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    case (state_q)
      StAddr: begin
        strb.cs  = 1'b0;
        strb.a_d = 1'b0;
        strb.wr  = 1'b0;
        io_oe    = 1'b1;
        io_out   = addr_q;
      end
      StData: begin
        strb.cs = 1'b0;
        if (dir_q == GntWrite) begin
          strb.wr = 1'b0;
          io_oe   = 1'b1;
          io_out  = data_q;
        end else begin
          strb.rd = 1'b0;
        end
      end
`ifdef RTC_WRITE_VERIFY_EN
      StVerifyAddr: begin
        strb.cs  = 1'b0;
        strb.a_d = 1'b0;
        strb.wr  = 1'b0;
        io_oe    = 1'b1;
        io_out   = addr_q;
      end
      StVerifyData: begin
        strb.cs = 1'b0;
        strb.rd = 1'b0;
      end
`endif
      StDone: begin
        wr_ack = (dir_q == GntWrite);
        rd_ack = (dir_q == GntRead);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= GntRead;
      dir_q        <= GntRead;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (latch) begin
        dir_q  <= grant_sel;
        addr_q <= (grant_sel == GntWrite) ? wr_addr : rd_addr;
        data_q <= wr_data;
      end
      if (state_q == StData && dir_q == GntRead && tmr_done) begin
        rd_data_q <= io_in;
      end
    end
  end

`ifdef RTC_WRITE_VERIFY_EN
  logic wr_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_q <= 1'b0;
    end else if (state_q == StVerifyData && tmr_done) begin
      wr_err_q <= (io_in != data_q);
    end
  end

  assign wr_err = wr_err_q;
`endif

  assign A_D     = strb.a_d;
  assign RD      = strb.rd;
  assign WR      = strb.wr;
  assign CS      = strb.cs;
  assign rd_data = rd_data_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: directed scenarios plus random request mixes against a
// cycle-offset model of the bus phases and a round-robin arbitration model.
module tb_rtc_bus_sequencer;

  localparam int TP  = 4;
  localparam int TG  = 2;
  localparam int Seg = 2 * TP + TG;
`ifdef RTC_WRITE_VERIFY_EN
  localparam bit Verify = 1'b1;
`else
  localparam bit Verify = 1'b0;
`endif
  localparam logic [15:0] IdleVec = {4'b1111, 1'b0, 8'h00, 3'b000};

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req, rd_req;
  logic [7:0] wr_addr, wr_data, rd_addr, io_in;
  logic       wr_ack, rd_ack, A_D, RD, WR, CS, io_oe, busy;
  logic [7:0] rd_data, io_out;
`ifdef RTC_WRITE_VERIFY_EN
  logic       wr_err;
`endif

  int         n_tests = 0;
  int         n_fail = 0;
  bit         last_rd = 1'b1;
  logic [7:0] exp_rd_data = 8'h00;

  rtc_bus_sequencer #(
    .T_PULSE(TP),
    .T_GAP  (TG),
    .CNT_W  (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_req (wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack (wr_ack),
    .rd_req (rd_req),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_ack (rd_ack),
    .A_D    (A_D),
    .RD     (RD),
    .WR     (WR),
    .CS     (CS),
    .io_out (io_out),
    .io_oe  (io_oe),
    .io_in  (io_in),
    .busy   (busy)
`ifdef RTC_WRITE_VERIFY_EN
    ,
    .wr_err (wr_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {CS, A_D, WR, RD, io_oe, io_out (only meaningful while driven), wr_ack, rd_ack, busy}
  function automatic logic [15:0] obs_vec();
    return {CS, A_D, WR, RD, io_oe, (io_oe ? io_out : 8'h00), wr_ack, rd_ack, busy};
  endfunction

  // Expected bus state in cycle i of a transaction of length len.
  function automatic logic [15:0] exp_vec(input int i, input bit is_wr, input logic [7:0] a,
                                          input logic [7:0] d, input int len);
    int p;
    bit rd_seg;
    p      = i % Seg;
    rd_seg = !is_wr || (i >= Seg);
    if (i == len - 1) return {4'b1111, 1'b0, 8'h00, is_wr, !is_wr, 1'b1};
    if (p < TP) return {4'b0001, 1'b1, a, 3'b001};
    if (p < TP + TG) return {4'b1111, 1'b0, 8'h00, 3'b001};
    if (rd_seg) return {4'b0110, 1'b0, 8'h00, 3'b001};
    return {4'b0101, 1'b1, d, 3'b001};
  endfunction

  // Called at a negedge inside an IDLE cycle with requests already set; returns at the
  // negedge of the IDLE cycle that follows the transaction.
  task automatic run_one(input bit fixed, input logic [7:0] fixed_io, input int drop_at,
                         input bit keep);
    bit         g_wr;
    bit         exp_err;
    logic [7:0] a, d;
    int         len;
    if (!wr_req && !rd_req) return;
    g_wr    = wr_req && (!rd_req || last_rd);
    last_rd = !g_wr;
    a       = g_wr ? wr_addr : rd_addr;
    d       = wr_data;
    len     = (g_wr && Verify) ? 2 * Seg + 1 : Seg + 1;
    exp_err = 1'b0;
    if (fixed) io_in = fixed_io;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("%s_cycle%0d", g_wr ? "wr" : "rd", i), obs_vec(),
            exp_vec(i, g_wr, a, d, len));
      if (i == len - 1) begin
        check("rd_data", rd_data, exp_rd_data);
`ifdef RTC_WRITE_VERIFY_EN
        if (g_wr) check("wr_err", wr_err, exp_err);
`endif
        if (!keep) begin
          if (g_wr) wr_req = 1'b0;
          else rd_req = 1'b0;
        end
      end
      if (i == drop_at) begin
        if (g_wr) wr_req = 1'b0;
        else rd_req = 1'b0;
      end
      wr_addr = 8'($urandom);
      wr_data = 8'($urandom);
      rd_addr = 8'($urandom);
      if (!fixed) io_in = 8'($urandom);
      if (!g_wr && i == Seg - 1) exp_rd_data = io_in;
      if (g_wr && Verify && i == 2 * Seg - 1) exp_err = (io_in != d);
    end
    @(negedge clk);
    check("idle_gap", obs_vec(), IdleVec);
  endtask

  initial begin
    int r;
    reset   = 1'b1;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    rd_addr = 8'h00;
    io_in   = 8'h00;
    #1;
    check("reset_outputs", obs_vec(), IdleVec);
    check("reset_rd_data", rd_data, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", obs_vec(), IdleVec);

    // Directed write then read.
    wr_addr = 8'h21;
    wr_data = 8'h59;
    wr_req  = 1'b1;
    run_one(1'b0, 8'h00, -1, 1'b0);
    rd_addr = 8'h22;
    rd_req  = 1'b1;
    run_one(1'b1, 8'h37, -1, 1'b0);
    check("rd_data_37", rd_data, 8'h37);

    // Both requests held from reset: write, read, write, read.
    reset = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    last_rd = 1'b1;
    exp_rd_data = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) run_one(1'b0, 8'h00, -1, 1'b1);
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    check("rr_released_idle", obs_vec(), IdleVec);

    // Read request dropped two cycles into ADDR.
    rd_req = 1'b1;
    run_one(1'b0, 8'h00, 1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("no_second_txn", obs_vec(), IdleVec);
    end

    // Random request mixes.
    for (int k = 0; k < 16; k++) begin
      if (!wr_req && !rd_req) begin
        r = int'($urandom_range(1, 3));
        wr_req = r[0];
        rd_req = r[1];
      end else if ($urandom_range(0, 1) == 1) begin
        wr_req = 1'b1;
        rd_req = 1'b1;
      end
      run_one(1'b0, 8'h00, -1, 1'b0);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);

    // Async reset during the DATA phase of a write.
    wr_addr = 8'($urandom);
    wr_data = 8'($urandom);
    wr_req  = 1'b1;
    repeat (TP + TG + 2) @(negedge clk);
    check("pre_reset_wr_low", WR, 1'b0);
    #1 reset = 1'b1;
    #1 check("async_reset_outputs", obs_vec(), IdleVec);
    last_rd = 1'b1;
    exp_rd_data = 8'h00;
    repeat (2) begin
      @(negedge clk);
      check("no_ack_in_reset", obs_vec(), IdleVec);
    end
    reset = 1'b0;
    run_one(1'b0, 8'h00, -1, 1'b0);

`ifdef RTC_WRITE_VERIFY_EN
    // Readback mismatch then match.
    wr_addr = 8'h40;
    wr_data = 8'h12;
    wr_req  = 1'b1;
    run_one(1'b1, 8'h13, -1, 1'b0);
    check("verify_err_set", wr_err, 1'b1);
    wr_addr = 8'h40;
    wr_data = 8'h12;
    wr_req  = 1'b1;
    run_one(1'b1, 8'h12, -1, 1'b0);
    check("verify_err_clear", wr_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
